mae_share_sched: RTL and testbench



---
 rtl/mae_share_sched.sv | 186 ++++++++++++++++++
 tb/tb_mae_share_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mae_share_sched.sv
// Round-robin scheduler sharing one MAE multiply-add DSP slice among NREQ requesters.
// Define MAE_SHARE_SCHED_ACC_EN for per-requester accumulators with MAC hazard tracking.
module mae_share_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               CLK,
  input  logic               ARST_N,
  input  logic [NREQ-1:0]    REQ_VALID,
  output logic [NREQ-1:0]    REQ_READY,
  input  logic [2*NREQ-1:0]  REQ_OP,
  input  logic [18*NREQ-1:0] REQ_A,
  input  logic [18*NREQ-1:0] REQ_B,
  input  logic [40*NREQ-1:0] REQ_C,
  output logic [17:0]        DSP_A,
  output logic [17:0]        DSP_B,
  output logic [39:0]        DSP_C,
  input  logic [39:0]        DSP_P,
  output logic               RES_VALID,
  output logic [IDW-1:0]     RES_ID,
  output logic [39:0]        RES_P
);

  typedef enum logic [1:0] {
    OP_MUL     = 2'b00,
    OP_MAC_CLR = 2'b01,
    OP_MAC     = 2'b10,
    OP_ADDC    = 2'b11
  } op_e;

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
    op_e            op;
  } tag_t;

  tag_t            tag_q [LAT];
  tag_t            wb;
  logic [IDW-1:0]  last_grant;
  logic [NREQ-1:0] elig;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic            xfer;
  op_e             sel_op;
  logic [17:0]     sel_a;
  logic [17:0]     sel_b;
  logic [39:0]     sel_c;
  logic [39:0]     c_nxt;

  assign wb     = tag_q[LAT-1];
  assign xfer   = |(REQ_VALID & REQ_READY);
  assign sel_op = op_e'(REQ_OP[2*gnt_id +: 2]);
  assign sel_a  = REQ_A[18*gnt_id +: 18];
  assign sel_b  = REQ_B[18*gnt_id +: 18];
  assign sel_c  = REQ_C[40*gnt_id +: 40];

`ifdef MAE_SHARE_SCHED_ACC_EN
  logic [39:0]     acc [NREQ];
  logic [NREQ-1:0] pend;
  logic            wb_acc;
  logic            byp;

  assign wb_acc = wb.vld &&
                  (wb.op == OP_MAC || wb.op == OP_MAC_CLR);
  assign byp    = wb_acc && (wb.id == gnt_id);

  // Accumulating jobs still ahead of their writeback edge block a new MAC.
  always_comb begin
    pend = '0;
    for (int s = 0; s < LAT-1; s++) begin
      if (tag_q[s].vld &&
          (tag_q[s].op == OP_MAC ||
           tag_q[s].op == OP_MAC_CLR))
        pend[tag_q[s].id] = 1'b1;
    end
  end

  // A MAC waits while its requester's accumulator is stale.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = REQ_VALID[i] &
                ~((op_e'(REQ_OP[2*i +: 2]) == OP_MAC) &
                  pend[i]);
    end
  end
`else
  assign elig = REQ_VALID;
`endif

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!gnt_any &&
          elig[(int'(last_grant) + k) % NREQ]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'((int'(last_grant) + k) % NREQ);
      end
    end
  end

  // One-hot ready, forced low while reset is asserted.
  always_comb begin
    REQ_READY = '0;
    if (gnt_any && ARST_N)
      REQ_READY[gnt_id] = 1'b1;
  end

  // Addend selection; MAC takes the accumulator or the value being written back.
  always_comb begin
    c_nxt = '0;
    unique case (1'b1)
      (sel_op == OP_ADDC): c_nxt = sel_c;
`ifdef MAE_SHARE_SCHED_ACC_EN
      (sel_op == OP_MAC):  c_nxt = byp ? DSP_P : acc[gnt_id];
`endif
      default:             c_nxt = '0;
    endcase
  end

  // DSP operand registers load only on a transfer.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      DSP_A <= '0;
      DSP_B <= '0;
      DSP_C <= '0;
    end else if (xfer) begin
      DSP_A <= sel_a;
      DSP_B <= sel_b;
      DSP_C <= c_nxt;
    end
  end

  // Round-robin pointer moves only when a grant is taken.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N)
      last_grant <= IDW'(NREQ-1);
    else if (xfer)
      last_grant <= gnt_id;
  end

  // Tag pipeline follows each job through the DSP latency.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      for (int s = 0; s < LAT; s++)
        tag_q[s] <= '0;
    end else begin
      tag_q[0].vld <= xfer;
      tag_q[0].id  <= gnt_id;
      tag_q[0].op  <= sel_op;
      for (int s = 1; s < LAT; s++)
        tag_q[s] <= tag_q[s-1];
    end
  end

  // Result strobe and held result/id registers.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      RES_VALID <= 1'b0;
      RES_ID    <= '0;
      RES_P     <= '0;
    end else begin
      RES_VALID <= wb.vld;
      if (wb.vld) begin
        RES_ID <= wb.id;
        RES_P  <= DSP_P;
      end
    end
  end

`ifdef MAE_SHARE_SCHED_ACC_EN
  // Accumulator writeback for MAC and MAC_CLR results.
  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      for (int i = 0; i < NREQ; i++)
        acc[i] <= '0;
    end else if (wb_acc) begin
      acc[wb.id] <= DSP_P;
    end
  end
`endif

endmodule

// File: tb/tb_mae_share_sched.sv
// Directed bench for mae_share_sched with a behavioural LAT=2 DSP model.
// Expectations follow MAE_SHARE_SCHED_ACC_EN when defined.
module tb_mae_share_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam logic [1:0] MUL  = 2'b00;
  localparam logic [1:0] MCL  = 2'b01;
  localparam logic [1:0] MAC  = 2'b10;
  localparam logic [1:0] ADDC = 2'b11;

  logic               CLK;
  logic               ARST_N;
  logic [NREQ-1:0]    REQ_VALID;
  logic [NREQ-1:0]    REQ_READY;
  logic [2*NREQ-1:0]  REQ_OP;
  logic [18*NREQ-1:0] REQ_A;
  logic [18*NREQ-1:0] REQ_B;
  logic [40*NREQ-1:0] REQ_C;
  logic [17:0]        DSP_A;
  logic [17:0]        DSP_B;
  logic [39:0]        DSP_C;
  logic [39:0]        DSP_P;
  logic               RES_VALID;
  logic [1:0]         RES_ID;
  logic [39:0]        RES_P;

  int vecs;
  int errs;

  mae_share_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .CLK(CLK), .ARST_N(ARST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OP(REQ_OP), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .REQ_C(REQ_C),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_C(DSP_C),
    .DSP_P(DSP_P),
    .RES_VALID(RES_VALID), .RES_ID(RES_ID), .RES_P(RES_P)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [39:0] ea, eb, dsp_q;
  assign ea    = {{22{DSP_A[17]}}, DSP_A};
  assign eb    = {{22{DSP_B[17]}}, DSP_B};
  assign DSP_P = dsp_q;
  always @(posedge CLK) dsp_q <= ea * eb + DSP_C;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_all;
    REQ_VALID = '0;
    REQ_OP    = '0;
    REQ_A     = '0;
    REQ_B     = '0;
    REQ_C     = '0;
  endtask

  task automatic set_req(input int i, input logic [1:0] op,
                         input logic [17:0] a,
                         input logic [17:0] b,
                         input logic [39:0] c);
    REQ_VALID[i]      = 1'b1;
    REQ_OP[2*i +: 2]  = op;
    REQ_A[18*i +: 18] = a;
    REQ_B[18*i +: 18] = b;
    REQ_C[40*i +: 40] = c;
  endtask

  task automatic do_reset;
    idle_all();
    ARST_N = 1'b0;
    tick();
    tick();
    ARST_N = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    idle_all();
    ARST_N = 1'b1;
    #2;
    ARST_N = 1'b0;
    REQ_VALID = '1;
    #1;
    if (REQ_READY !== 4'b0000) begin
      errs++;
      $display("FAIL rst_ready got %b want 0000", REQ_READY);
    end
    vecs++;
    tick();
    if (REQ_READY !== 4'b0000) begin
      errs++;
      $display("FAIL rst_ready_clk got %b want 0000", REQ_READY);
    end
    vecs++;
    if (RES_VALID !== 1'b0 || RES_ID !== 2'd0 || RES_P !== 40'd0) begin
      errs++;
      $display("FAIL rst_res got v=%b id=%0d p=%h want 0/0/0",
               RES_VALID, RES_ID, RES_P);
    end
    vecs++;
    if (DSP_A !== 18'd0 || DSP_B !== 18'd0 || DSP_C !== 40'd0) begin
      errs++;
      $display("FAIL rst_dsp got a=%h b=%h c=%h want 0", DSP_A, DSP_B, DSP_C);
    end
    vecs++;
    idle_all();
    ARST_N = 1'b1;
    tick();
  endtask

  task automatic test_single_mul;
    set_req(2, MUL, -18'sd3, 18'sd5, 40'd0);
    #1;
    if (REQ_READY !== 4'b0100) begin
      errs++;
      $display("FAIL mul_ready got %b want 0100", REQ_READY);
    end
    vecs++;
    tick();
    REQ_VALID[2] = 1'b0;
    if (DSP_A !== 18'h3FFFD || DSP_B !== 18'd5 || DSP_C !== 40'd0) begin
      errs++;
      $display("FAIL mul_dsp got a=%h b=%h c=%h want 3fffd/5/0",
               DSP_A, DSP_B, DSP_C);
    end
    vecs++;
    tick();
    if (RES_VALID !== 1'b0) begin
      errs++;
      $display("FAIL mul_early got %b want 0", RES_VALID);
    end
    vecs++;
    tick();
    if (RES_VALID !== 1'b1 || RES_ID !== 2'd2 || RES_P !== 40'hFF_FFFF_FFF1) begin
      errs++;
      $display("FAIL mul_res got v=%b id=%0d p=%h want 1/2/fffffffff1",
               RES_VALID, RES_ID, RES_P);
    end
    vecs++;
    tick();
    if (RES_VALID !== 1'b0 || RES_P !== 40'hFF_FFFF_FFF1) begin
      errs++;
      $display("FAIL mul_hold got v=%b p=%h want 0/fffffffff1",
               RES_VALID, RES_P);
    end
    vecs++;
  endtask

  task automatic test_rr;
    int exp_p;
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_req(i, MUL, 18'(i + 1), 18'd10, 40'd0);
    for (int k = 0; k < 10; k++) begin
      if (k == 8) idle_all();
      #1;
      if (k < 8) begin
        if (REQ_READY !== 4'(1 << (k % 4))) begin
          errs++;
          $display("FAIL rr_ready[%0d] got %b want %b",
                   k, REQ_READY, 4'(1 << (k % 4)));
        end
        vecs++;
      end
      tick();
      if (k >= 2) begin
        exp_p = ((k - 2) % 4 + 1) * 10;
        if (RES_VALID !== 1'b1 || RES_ID !== 2'((k - 2) % 4) ||
            RES_P !== 40'(exp_p)) begin
          errs++;
          $display("FAIL rr_res[%0d] got v=%b id=%0d p=%0d want 1/%0d/%0d",
                   k, RES_VALID, RES_ID, RES_P, (k - 2) % 4, exp_p);
        end
        vecs++;
      end
    end
    idle_all();
    tick();
  endtask

  task automatic test_mac;
    logic [1:0]  ops [3];
    logic [17:0] as  [3];
    logic [17:0] bs  [3];
    bit          exp_rdy [5];
    bit          res_v   [8];
    int          res_val [8];
    int          nops;
    int          j;
    bit          took;
    ops = '{MCL, MAC, MAC};
    as  = '{18'd2, 18'd4, 18'd1};
    bs  = '{18'd3, 18'd5, 18'd1};
`ifdef MAE_SHARE_SCHED_ACC_EN
    nops    = 3;
    exp_rdy = '{1, 0, 1, 0, 1};
    res_v   = '{0, 0, 1, 0, 1, 0, 1, 0};
    res_val = '{0, 0, 6, 0, 26, 0, 27, 0};
`else
    ops[0]  = MAC;
    nops    = 2;
    exp_rdy = '{1, 1, 0, 0, 0};
    res_v   = '{0, 0, 1, 1, 0, 0, 0, 0};
    res_val = '{0, 0, 6, 20, 0, 0, 0, 0};
`endif
    do_reset();
    j = 0;
    for (int c = 0; c < 8; c++) begin
      if (j < nops) set_req(1, ops[j], as[j], bs[j], 40'd0);
      else REQ_VALID[1] = 1'b0;
      #1;
      if (c < 5) begin
        if (REQ_READY[1] !== exp_rdy[c]) begin
          errs++;
          $display("FAIL mac_ready[%0d] got %b want %b",
                   c, REQ_READY[1], exp_rdy[c]);
        end
        vecs++;
      end
      took = REQ_READY[1] && (j < nops);
      tick();
      if (took) j++;
      if (RES_VALID !== res_v[c] ||
          (res_v[c] && (RES_ID !== 2'd1 || RES_P !== 40'(res_val[c])))) begin
        errs++;
        $display("FAIL mac_res[%0d] got v=%b id=%0d p=%0d want %b/1/%0d",
                 c, RES_VALID, RES_ID, RES_P, res_v[c], res_val[c]);
      end
      vecs++;
    end
    idle_all();
  endtask

  task automatic test_addc;
    set_req(0, ADDC, 18'sd131071, 18'sd131071, -40'sd1);
    #1;
    if (REQ_READY !== 4'b0001) begin
      errs++;
      $display("FAIL addc_ready got %b want 0001", REQ_READY);
    end
    vecs++;
    tick();
    idle_all();
    tick();
    tick();
    if (RES_VALID !== 1'b1 || RES_ID !== 2'd0 ||
        RES_P !== 40'd17179607040) begin
      errs++;
      $display("FAIL addc_res got v=%b id=%0d p=%0d want 1/0/17179607040",
               RES_VALID, RES_ID, RES_P);
    end
    vecs++;
    tick();
  endtask

  task automatic test_hazard;
    logic [3:0] exp_rdy [7];
    bit         res_v   [7];
    logic [1:0] res_id  [7];
    int         res_val [7];
    exp_rdy = '{4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    res_v   = '{0, 0, 1, 1, 1, 1, 0};
    res_id  = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd0};
`ifdef MAE_SHARE_SCHED_ACC_EN
    res_val = '{0, 0, 2, 9, 4, 9, 0};
`else
    res_val = '{0, 0, 2, 9, 2, 9, 0};
`endif
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c <= 2) set_req(3, MAC, 18'd1, 18'd2, 40'd0);
      else REQ_VALID[3] = 1'b0;
      if (c >= 1 && c <= 3) set_req(0, MUL, 18'd3, 18'd3, 40'd0);
      else REQ_VALID[0] = 1'b0;
      #1;
      if (REQ_READY !== exp_rdy[c]) begin
        errs++;
        $display("FAIL haz_ready[%0d] got %b want %b",
                 c, REQ_READY, exp_rdy[c]);
      end
      vecs++;
      tick();
      if (RES_VALID !== res_v[c] ||
          (res_v[c] && (RES_ID !== res_id[c] ||
                        RES_P !== 40'(res_val[c])))) begin
        errs++;
        $display("FAIL haz_res[%0d] got v=%b id=%0d p=%0d want %b/%0d/%0d",
                 c, RES_VALID, RES_ID, RES_P, res_v[c], res_id[c], res_val[c]);
      end
      vecs++;
    end
    idle_all();
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_req(i, MAC, 18'd5, 18'd5, 40'd0);
    for (int c = 0; c < 4; c++) begin
      #1;
      if (REQ_READY !== 4'(1 << c)) begin
        errs++;
        $display("FAIL mid_ready[%0d] got %b want %b",
                 c, REQ_READY, 4'(1 << c));
      end
      vecs++;
      tick();
    end
    idle_all();
    ARST_N = 1'b0;
    #1;
    if (RES_VALID !== 1'b0) begin
      errs++;
      $display("FAIL mid_async got %b want 0", RES_VALID);
    end
    vecs++;
    tick();
    ARST_N = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (RES_VALID !== 1'b0) begin
        errs++;
        $display("FAIL mid_drop[%0d] got %b want 0", c, RES_VALID);
      end
      vecs++;
    end
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, MAC, 18'd3, 18'd7, 40'd0);
      tick();
      REQ_VALID[i] = 1'b0;
      tick();
      tick();
      if (RES_VALID !== 1'b1 || RES_ID !== 2'(i) || RES_P !== 40'd21) begin
        errs++;
        $display("FAIL mid_acc[%0d] got v=%b id=%0d p=%0d want 1/%0d/21",
                 i, RES_VALID, RES_ID, RES_P, i);
      end
      vecs++;
    end
    idle_all();
    tick();
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_single_mul();
    test_rr();
    test_mac();
    test_addc();
    test_hazard();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
